game_controller: RTL and testbench

Parametrised top-level game-flow controller for the frogger design. It tracks the menu, playing, death, level-transition, game-over and victory phases, and manages the level index and remaining lives. It also emits single-cycle sound-event requests and win/lose pulses. It sits between the input debouncer/collision logic and the renderer/sound blocks, and supersedes the single-life, fixed-flow controller.

---
 rtl/game_controller.sv | 151 +++++++++++++++
 tb/tb_game_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Game-flow controller: menu, play, death, level-up, game-over and victory.
// Tracks level and lives, and emits sound requests and win/lose pulses.
module game_controller #(
    parameter int NUM_LEVELS  = 8,
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int LEVEL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    parameter int LIVES_W     = $clog2(LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         dpad_input,
    input  logic               collision,
    input  logic               reached_end,
    output logic [2:0]         state,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic               win,
    output logic               lose,
    output logic [1:0]         sound_sel,
    output logic               sound_play
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        PLAYING   = 3'd1,
        DYING     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4,
        VICTORY   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SND_UI_PRESS    = 2'd0,
        SND_NEXTLEVEL   = 2'd1,
        SND_CRASH       = 2'd2,
        SND_CELEBRATION = 2'd3
    } sound_e;

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] START_LIVES = LIVES_W'(LIVES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e             state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [3:0]         dpad_q;
    logic               win_q;
    logic               lose_q;
    logic               play_q;
    sound_e             sel_q;

    logic press;
    logic hold_done;

    assign press     = (dpad_input != 4'h0) && (dpad_q == 4'h0);
    assign hold_done = (hold_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            // All-ones keeps a button held through reset from starting a game
            dpad_q  <= 4'hF;
            state_q <= MENU;
            level_q <= '0;
            lives_q <= START_LIVES;
            hold_q  <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            play_q  <= 1'b0;
            sel_q   <= SND_UI_PRESS;
        end else begin
            dpad_q <= dpad_input;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
            play_q <= 1'b0;
            case (state_q)
                MENU: begin
                    if (press) begin
                        state_q <= PLAYING;
                        level_q <= '0;
                        lives_q <= START_LIVES;
                        hold_q  <= '0;
                        play_q  <= 1'b1;
                        sel_q   <= SND_UI_PRESS;
                    end
                end
                PLAYING: begin
                    if (collision) begin
                        lives_q <= lives_q - LIVES_W'(1);
                        lose_q  <= 1'b1;
                        play_q  <= 1'b1;
                        sel_q   <= SND_CRASH;
                        hold_q  <= '0;
                        if (lives_q == LIVES_W'(1)) begin
                            state_q <= GAME_OVER;
                        end else begin
                            state_q <= DYING;
                        end
                    end else if (reached_end) begin
                        play_q <= 1'b1;
                        hold_q <= '0;
                        if (level_q == LAST_LEVEL) begin
                            state_q <= VICTORY;
                            win_q   <= 1'b1;
                            sel_q   <= SND_CELEBRATION;
                        end else begin
                            state_q <= LEVEL_UP;
                            level_q <= level_q + LEVEL_W'(1);
                            sel_q   <= SND_NEXTLEVEL;
                        end
                    end
                end
                DYING, LEVEL_UP: begin
                    if (hold_done) begin
                        state_q <= PLAYING;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                GAME_OVER, VICTORY: begin
                    // Counter saturates; presses count only once it has
                    if (!hold_done) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end else if (press) begin
                        state_q <= MENU;
                        hold_q  <= '0;
                        play_q  <= 1'b1;
                        sel_q   <= SND_UI_PRESS;
                    end
                end
                default: begin
                    state_q <= MENU;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign level      = level_q;
    assign lives      = lives_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign sound_sel  = sel_q;
    assign sound_play = play_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed plan plus random play
// against a dwell-time based reference model.
module tb_game_controller;

    localparam int NL = 2;
    localparam int NLIV = 2;
    localparam int HOLD = 4;
    localparam int LW = 1;
    localparam int VW = 2;

    logic          clk;
    logic          reset;
    logic [3:0]    dpad_input;
    logic          collision;
    logic          reached_end;
    logic [2:0]    state;
    logic [LW-1:0] level;
    logic [VW-1:0] lives;
    logic          win;
    logic          lose;
    logic [1:0]    sound_sel;
    logic          sound_play;

    game_controller #(
        .NUM_LEVELS (NL),
        .LIVES      (NLIV),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dpad_input (dpad_input),
        .collision  (collision),
        .reached_end(reached_end),
        .state      (state),
        .level      (level),
        .lives      (lives),
        .win        (win),
        .lose       (lose),
        .sound_sel  (sound_sel),
        .sound_play (sound_play)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(
        input string tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: phase number plus the cycle the phase was entered
    int  m_phase, m_level, m_lives, m_sel;
    int  m_win, m_lose, m_play;
    int  m_now, m_entered;
    bit  m_down;

    task automatic m_goto(input int ph);
        m_phase   = ph;
        m_entered = m_now;
    endtask

    task automatic model_edge(
        input logic [3:0] d,
        input bit c,
        input bit r,
        input bit rs
    );
        bit pr;
        int dwell;
        m_now++;
        m_win = 0;
        m_lose = 0;
        m_play = 0;
        if (rs) begin
            m_phase = 0;
            m_level = 0;
            m_lives = NLIV;
            m_sel = 0;
            m_down = 1;
            m_entered = m_now;
            return;
        end
        pr = (d != 0) && !m_down;
        m_down = (d != 0);
        dwell = m_now - m_entered;
        if (m_phase == 0) begin
            if (pr) begin
                m_goto(1);
                m_level = 0;
                m_lives = NLIV;
                m_play = 1;
                m_sel = 0;
            end
        end else if (m_phase == 1) begin
            if (c) begin
                m_lives = m_lives - 1;
                m_lose = 1;
                m_play = 1;
                m_sel = 2;
                m_goto(m_lives == 0 ? 4 : 2);
            end else if (r) begin
                m_play = 1;
                if (m_level == NL - 1) begin
                    m_win = 1;
                    m_sel = 3;
                    m_goto(5);
                end else begin
                    m_level++;
                    m_sel = 1;
                    m_goto(3);
                end
            end
        end else if (m_phase == 2 || m_phase == 3) begin
            if (dwell >= HOLD) m_goto(1);
        end else begin
            if (dwell >= HOLD && pr) begin
                m_play = 1;
                m_sel = 0;
                m_goto(0);
            end
        end
    endtask

    task automatic step(
        input logic [3:0] d,
        input bit c,
        input bit r,
        input bit rs
    );
        dpad_input  = d;
        collision   = c;
        reached_end = r;
        reset       = rs;
        @(posedge clk);
        model_edge(d, c, r, rs);
        @(negedge clk);
        chk("state", 32'(state), 32'(m_phase));
        chk("level", 32'(level), 32'(m_level));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("win", 32'(win), 32'(m_win));
        chk("lose", 32'(lose), 32'(m_lose));
        chk("sound_play", 32'(sound_play), 32'(m_play));
        chk("sound_sel", 32'(sound_sel), 32'(m_sel));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 0, 0, 0);
    endtask

    task automatic start_game();
        step(4'h0, 0, 0, 1);
        idle(1);
        step(4'h2, 0, 0, 0);
        idle(1);
    endtask

    initial begin
        m_now = 0;
        dpad_input = 4'h1;
        collision = 0;
        reached_end = 0;
        reset = 1;
        @(negedge clk);

        // 1: held button through reset does not start
        step(4'h1, 0, 0, 1);
        step(4'h1, 0, 0, 1);
        chk("rst_state", 32'(state), 0);
        chk("rst_lives", 32'(lives), NLIV);
        chk("rst_play", 32'(sound_play), 0);
        step(4'h1, 0, 0, 0);
        step(4'h1, 0, 0, 0);
        chk("held_no_start", 32'(state), 0);
        idle(1);
        step(4'h2, 0, 0, 0);
        chk("start_state", 32'(state), 1);
        chk("start_sel", 32'(sound_sel), 0);
        chk("start_play", 32'(sound_play), 1);

        // 2: collision and dwell
        idle(1);
        step(4'h0, 1, 0, 0);
        chk("crash_state", 32'(state), 2);
        chk("crash_lose", 32'(lose), 1);
        chk("crash_sel", 32'(sound_sel), 2);
        idle(1);
        chk("crash_lose_off", 32'(lose), 0);
        idle(2);
        chk("dying_hold", 32'(state), 2);
        idle(1);
        chk("dying_back", 32'(state), 1);

        // 3: collision wins over reached_end
        start_game();
        step(4'h0, 1, 1, 0);
        chk("prio_state", 32'(state), 2);
        chk("prio_level", 32'(level), 0);
        chk("prio_lives", 32'(lives), 1);

        // 4: level up then victory
        start_game();
        step(4'h0, 0, 1, 0);
        chk("lvup_state", 32'(state), 3);
        chk("lvup_level", 32'(level), 1);
        chk("lvup_sel", 32'(sound_sel), 1);
        idle(4);
        chk("lvup_back", 32'(state), 1);
        step(4'h0, 0, 1, 0);
        chk("vic_state", 32'(state), 5);
        chk("vic_win", 32'(win), 1);
        chk("vic_sel", 32'(sound_sel), 3);
        idle(1);
        chk("vic_win_off", 32'(win), 0);

        // 5: game over, early press ignored
        start_game();
        step(4'h0, 1, 0, 0);
        idle(4);
        step(4'h0, 1, 0, 0);
        chk("go_state", 32'(state), 4);
        chk("go_lives", 32'(lives), 0);
        idle(1);
        step(4'h4, 0, 0, 0);
        idle(2);
        chk("go_early", 32'(state), 4);
        step(4'h8, 0, 0, 0);
        chk("go_menu", 32'(state), 0);
        chk("go_sel", 32'(sound_sel), 0);

        // 6: reset mid-hold
        start_game();
        step(4'h0, 1, 0, 0);
        idle(1);
        step(4'h0, 0, 0, 1);
        chk("rst_hold_state", 32'(state), 0);
        chk("rst_hold_lives", 32'(lives), NLIV);
        chk("rst_hold_lose", 32'(lose), 0);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] d;
            bit c, r, rs;
            d  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            c  = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 6) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(d, c, r, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
